mac_tx_fcs_ctrl: RTL and testbench
==================================

Name: mac_tx_fcs_ctrl

Overview:
- Sequences the byte-wide CRC-32 engine for the Ethernet MAC transmit path.
- Forwards each upstream frame byte-for-byte, zero-pads short frames to MIN_LEN bytes, then appends the 4-byte FCS.
- Owns the engine's clear and advance controls, so upstream logic never handles CRC state.
- Sits between the UDP/IP frame builder and the PHY-side TX interface.

Parameters:
- MIN_LEN, 60, minimum pre-FCS frame length in bytes (0 disables padding); legal range 0..2047.
- CNT_W, 11, byte counter width; counter saturates at 2^CNT_W-1.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  reset, asynchronous, active-high.
- s_data  in  8  upstream frame byte.
- s_valid  in  1  upstream byte valid.
- s_last  in  1  marks final payload byte; qualified by s_valid.
- s_ready  out  1  upstream byte accepted when s_valid&s_ready.
- m_data  out  8  downstream byte.
- m_valid  out  1  downstream byte valid.
- m_last  out  1  marks final FCS byte.
- m_ready  in  1  downstream accept.
- o_busy  out  1  high in any state other than IDLE.
- o_frame_done  out  1  one-cycle pulse after the final FCS byte is accepted.

Behaviour:
- Reset: state=IDLE, cnt=0, fcs_idx=0, CRC register=0xFFFFFFFF. All outputs 0: s_ready, m_valid, m_last, o_busy, o_frame_done. m_data=0.
- States: IDLE, DATA, PAD, FCS.
- IDLE:
  - s_ready=0, m_valid=0.
  - Registered crc_clr pulse for one cycle; engine reset = i_rst | crc_clr.
  - Next cycle: DATA. This gives exactly one bubble cycle between frames.
- DATA (zero-latency pass-through):
  - m_data=s_data, m_valid=s_valid, s_ready=m_ready, m_last=0.
  - Engine enable = s_valid&m_ready; engine data = s_data; cnt increments on each accepted byte.
  - On an accepted byte with s_last=1: go to PAD if cnt+1 < MIN_LEN, else FCS. A 1-byte frame is legal.
- PAD:
  - m_data=0x00, m_valid=1, s_ready=0.
  - Engine enable = m_ready with data 0x00; cnt increments on each accepted byte.
  - On the accept that makes cnt==MIN_LEN: go to FCS.
- FCS:
  - Engine enable=0, s_ready=0, m_valid=1.
  - m_data = FCS byte fcs_idx, taken from the engine's 32-bit FCS output (already reflected and inverted): byte 0 = bits[7:0], then [15:8], [23:16], [31:24].
  - fcs_idx advances on m_ready. m_last=1 when fcs_idx==3.
  - On the accept of byte 3: o_frame_done pulses next cycle, cnt=0, fcs_idx=0, go to IDLE.
- Backpressure: m_ready=0 in any state holds state, cnt, fcs_idx and the CRC register; m_data is stable while m_valid=1.
- Engine output is valid the cycle after the last enabled byte. FCS state is always entered at least one cycle after the last enable, so no forwarding path is needed.
- s_valid=0 in mid-frame DATA: m_valid=0; no CRC advance; no timeout.
- cnt saturates at its maximum; frames of 2047 bytes or more skip padding correctly.
- Reset asserted mid-frame: immediate return to IDLE with reset values; the partial frame is truncated, with no m_last.

Decomposition:
- Shared package mac_pkg:
  - state encoding enum (IDLE/DATA/PAD/FCS);
  - ETH_MIN_PAYLOAD=60;
  - FCS_BYTES=4;
  - CRC_INIT=32'hFFFFFFFF.
- Sub-module: the existing byte-wide CRC32_D8 engine, instantiated once. Controller drives its i_en, i_data and reset, and reads o_crc.

Test Plan:
- MIN_LEN=0, payload ASCII "123456789" (0x31..0x39), m_ready=1 -> 9 bytes passed unchanged, then FCS bytes 0x26,0x39,0xF4,0xCB; m_last on 0xCB; o_frame_done one cycle later.
- MIN_LEN=60, 14-byte frame -> 46 bytes of 0x00, then 4 FCS bytes matching a reference CRC over the 60 bytes; 64 output bytes total.
- MIN_LEN=60, 60-byte and 61-byte frames -> no padding; FCS follows immediately; totals 64 and 65 bytes.
- Random m_ready (50%) and random s_valid gaps on a 100-byte frame -> output byte sequence identical to the m_ready=1 run; no byte dropped or duplicated.
- Two back-to-back 1-byte frames (MIN_LEN=0) -> each frame gets a correct independent FCS; exactly one idle cycle between frames.
- i_rst asserted during PAD -> outputs reset immediately; the next frame's FCS is correct (CRC reinitialised).

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC transmit path: FSM encoding, frame constants
// and the reflected CRC-32 byte-update function used by the CRC engine.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2,
    FCS  = 2'd3
  } state_e;

  localparam int          ETH_MIN_PAYLOAD = 60;
  localparam int          FCS_BYTES       = 4;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB88320;

  // LSB-first update of the CRC register by one byte.
  function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc,
                                                input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 engine. o_crc is the finished FCS value
// (register already reflected by the LSB-first update, then inverted).
module crc32_d8
  import mac_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] crc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      crc <= CRC_INIT;
    else if (i_en)
      crc <= crc32_d8_next(crc, i_data);
  end

  assign o_crc = ~crc;

endmodule

// File: rtl/mac_tx_fcs_ctrl.sv
// TX FCS sequencer: forwards frame bytes, zero-pads to MIN_LEN, appends the
// 4-byte FCS and owns the CRC engine's clear/advance controls.
module mac_tx_fcs_ctrl
  import mac_pkg::*;
#(
  parameter int MIN_LEN = ETH_MIN_PAYLOAD,
  parameter int CNT_W   = 11
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   MIN_LEN_W = MIN_LEN[CNT_W:0];
  localparam logic [1:0]       FCS_LAST  = 2'(FCS_BYTES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       fcs_idx;
  logic             crc_clr;
  logic             crc_rst;
  logic             crc_en;
  logic [7:0]       crc_data;
  logic [31:0]      crc_fcs;
  logic [7:0]       fcs_byte;

  // Saturating count keeps oversized frames from wrapping back into PAD.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign o_busy  = (state != IDLE);
  assign crc_rst = i_rst | crc_clr;

  always_comb begin
    fcs_byte = crc_fcs[7:0];
    case (fcs_idx)
      2'd0: fcs_byte = crc_fcs[7:0];
      2'd1: fcs_byte = crc_fcs[15:8];
      2'd2: fcs_byte = crc_fcs[23:16];
      2'd3: fcs_byte = crc_fcs[31:24];
      default: fcs_byte = crc_fcs[7:0];
    endcase
  end

  always_comb begin
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data   = 8'h00;
    crc_en   = 1'b0;
    crc_data = 8'h00;
    case (state)
      DATA: begin
        m_data   = s_data;
        m_valid  = s_valid;
        s_ready  = m_ready;
        crc_en   = s_valid & m_ready;
        crc_data = s_data;
      end
      PAD: begin
        m_valid = 1'b1;
        crc_en  = m_ready;
      end
      FCS: begin
        m_valid = 1'b1;
        m_last  = (fcs_idx == FCS_LAST);
        m_data  = fcs_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      fcs_idx      <= '0;
      crc_clr      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      crc_clr      <= 1'b0;
      o_frame_done <= 1'b0;
      case (state)
        IDLE: state <= DATA;
        DATA: begin
          if (s_valid && m_ready) begin
            cnt <= cnt_inc;
            if (s_last)
              state <= ({1'b0, cnt_inc} < MIN_LEN_W) ? PAD : FCS;
          end
        end
        PAD: begin
          if (m_ready) begin
            cnt <= cnt_inc;
            if ({1'b0, cnt_inc} == MIN_LEN_W)
              state <= FCS;
          end
        end
        FCS: begin
          if (m_ready) begin
            fcs_idx <= fcs_idx + 1'b1;
            // Clear pulse lands in the IDLE bubble, so the next frame starts from CRC_INIT.
            if (fcs_idx == FCS_LAST) begin
              state        <= IDLE;
              cnt          <= '0;
              fcs_idx      <= '0;
              crc_clr      <= 1'b1;
              o_frame_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  crc32_d8 u_crc (
    .i_clk  (i_clk),
    .i_rst  (crc_rst),
    .i_en   (crc_en),
    .i_data (crc_data),
    .o_crc  (crc_fcs)
  );

endmodule

// File: tb/tb_mac_tx_fcs_ctrl.sv
// Directed bench for mac_tx_fcs_ctrl: two instances (MIN_LEN 0 and 60) share
// stimulus; a queue model of the expected byte stream is checked every beat.
module tb_mac_tx_fcs_ctrl;

  logic       i_clk    = 1'b0;
  logic       i_rst    = 1'b1;
  logic [7:0] s_data   = 8'h00;
  logic       s_valid  = 1'b0;
  logic       s_last   = 1'b0;
  logic       m_ready  = 1'b1;
  logic       sel      = 1'b0;
  logic       rand_rdy = 1'b0;

  logic [1:0]      s_ready_v, m_valid_v, m_last_v, busy_v, done_v;
  logic [1:0][7:0] m_data_v;
  logic            s_ready, m_valid, m_last, o_busy, o_frame_done;
  logic [7:0]      m_data;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  cap[$];
  logic [7:0]  ref_cap[$];
  int          cap_cyc[$];
  logic [7:0]  pl[$];
  logic [31:0] crc_tab[256];
  logic [31:0] tab_c;

  bit         mon_done_exp, mon_after_idle, mon_hold_v;
  logic [7:0] mon_hold_d;
  logic [8:0] mon_e;

  always #5 i_clk = ~i_clk;

  assign s_ready      = s_ready_v[sel];
  assign m_valid      = m_valid_v[sel];
  assign m_last       = m_last_v[sel];
  assign m_data       = m_data_v[sel];
  assign o_busy       = busy_v[sel];
  assign o_frame_done = done_v[sel];

  mac_tx_fcs_ctrl #(.MIN_LEN(0), .CNT_W(11)) u_nopad (
    .i_clk(i_clk), .i_rst(i_rst), .s_data(s_data), .s_valid(s_valid & ~sel),
    .s_last(s_last), .s_ready(s_ready_v[0]), .m_data(m_data_v[0]),
    .m_valid(m_valid_v[0]), .m_last(m_last_v[0]), .m_ready(m_ready),
    .o_busy(busy_v[0]), .o_frame_done(done_v[0])
  );

  mac_tx_fcs_ctrl #(.MIN_LEN(60), .CNT_W(11)) u_pad (
    .i_clk(i_clk), .i_rst(i_rst), .s_data(s_data), .s_valid(s_valid & sel),
    .s_last(s_last), .s_ready(s_ready_v[1]), .m_data(m_data_v[1]),
    .m_valid(m_valid_v[1]), .m_last(m_last_v[1]), .m_ready(m_ready),
    .o_busy(busy_v[1]), .o_frame_done(done_v[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) c = crc_tab[c[7:0] ^ b[i]] ^ (c >> 8);
    return ~c;
  endfunction

  // Expected wire image: payload, zero pad up to min_len, FCS low byte first.
  function automatic void expect_frame(input logic [7:0] p[$], input int min_len);
    logic [7:0]  f[$];
    logic [31:0] c;
    f = p;
    while (f.size() < min_len) f.push_back(8'h00);
    c = ref_crc(f);
    foreach (f[i]) exp_q.push_back({1'b0, f[i]});
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), c[8*k +: 8]});
  endfunction

  task automatic send(input logic [7:0] p[$], input bit gaps);
    int n;
    bit acc;
    bit all_acc;
    all_acc = 1'b1;
    for (int i = 0; i < p.size(); i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
      end
      s_valid = 1'b1;
      s_data  = p[i];
      s_last  = (i == p.size() - 1);
      n = 0; acc = 1'b0;
      while (!acc && n < 500) begin
        @(negedge i_clk); acc = s_ready;
        @(posedge i_clk); #1; n++;
      end
      if (!acc) begin all_acc = 1'b0; break; end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("upstream_accept", all_acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge i_clk); n++; end
    chk("drain_remaining", exp_q.size(), 0);
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  initial forever begin @(posedge i_clk); cyc++; end

  initial forever begin
    @(posedge i_clk); #1;
    m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every downstream beat against the model queue, plus
  // frame_done timing, the single IDLE bubble and hold-under-backpressure.
  initial begin
    mon_done_exp = 0; mon_after_idle = 0; mon_hold_v = 0; mon_hold_d = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        exp_q.delete();
        mon_done_exp = 0; mon_after_idle = 0; mon_hold_v = 0;
      end else begin
        chk("frame_done", o_frame_done, mon_done_exp);
        if (mon_after_idle) chk("busy_after_bubble", o_busy, 1);
        mon_after_idle = mon_done_exp;
        if (mon_done_exp) begin
          chk("bubble_busy", o_busy, 0);
          chk("bubble_s_ready", s_ready, 0);
          chk("bubble_m_valid", m_valid, 0);
        end
        if (mon_hold_v) begin
          chk("hold_m_valid", m_valid, 1);
          chk("hold_m_data", m_data, mon_hold_d);
        end
        mon_done_exp = 0;
        if (m_valid && m_ready) begin
          chk("beat_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("m_data", m_data, mon_e[7:0]);
            chk("m_last", m_last, mon_e[8]);
            if (mon_e[8]) mon_done_exp = 1;
          end
          cap.push_back(m_data);
          cap_cyc.push_back(cyc);
        end
        mon_hold_v = m_valid && !m_ready;
        mon_hold_d = m_data;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      tab_c = 32'(i);
      for (int k = 0; k < 8; k++) tab_c = tab_c[0] ? ((tab_c >> 1) ^ 32'hEDB88320) : (tab_c >> 1);
      crc_tab[i] = tab_c;
    end

    #2;
    chk("rst_m_valid", m_valid_v, 0);
    chk("rst_s_ready", s_ready_v, 0);
    chk("rst_m_last", m_last_v, 0);
    chk("rst_busy", busy_v, 0);
    chk("rst_frame_done", done_v, 0);
    chk("rst_m_data", m_data_v, 0);

    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_check", ref_crc(pl), 32'hCBF43926);
    pl = '{8'h00};
    chk("model_crc_00", ref_crc(pl), 32'hD202EF8D);

    #21 i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;

    // MIN_LEN=0, "123456789"
    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    cap.delete(); cap_cyc.delete();
    expect_frame(pl, 0); send(pl, 0); drain();
    chk("t1_len", cap.size(), 13);
    chk("t1_payload8", cap[8], 8'h39);
    chk("t1_fcs", {cap[12], cap[11], cap[10], cap[9]}, 32'hCBF43926);

    // Back-to-back 1-byte frames
    cap.delete(); cap_cyc.delete();
    pl = '{8'h00}; expect_frame(pl, 0); send(pl, 0);
    pl = '{8'h3C}; expect_frame(pl, 0); send(pl, 0);
    drain();
    chk("b2b_len", cap.size(), 10);
    chk("b2b_fcs0", {cap[4], cap[3], cap[2], cap[1]}, 32'hD202EF8D);
    chk("b2b_gap", cap_cyc[5] - cap_cyc[4], 2);

    // MIN_LEN=60 instance
    sel = 1'b1;
    @(posedge i_clk); #1;

    pl.delete();
    for (int i = 0; i < 14; i++) pl.push_back(8'(i + 1));
    cap.delete();
    expect_frame(pl, 60); send(pl, 0); drain();
    chk("pad14_len", cap.size(), 64);
    chk("pad14_byte13", cap[13], 8'd14);
    chk("pad14_byte59", cap[59], 8'h00);
    ref_cap = cap;

    pl.delete();
    for (int i = 0; i < 60; i++) pl.push_back(8'(i) ^ 8'h5A);
    cap.delete();
    expect_frame(pl, 60); send(pl, 0); drain();
    chk("len60_total", cap.size(), 64);

    pl.push_back(8'hEE);
    cap.delete();
    expect_frame(pl, 60); send(pl, 0); drain();
    chk("len61_total", cap.size(), 65);

    // 100-byte frame, then the same with random backpressure and gaps
    pl.delete();
    for (int i = 0; i < 100; i++) pl.push_back(8'($urandom));
    cap.delete();
    expect_frame(pl, 60); send(pl, 0); drain();
    chk("len100_total", cap.size(), 104);
    begin
      logic [7:0] steady[$];
      int nm;
      steady = cap;
      cap.delete();
      rand_rdy = 1'b1;
      expect_frame(pl, 60); send(pl, 1); drain();
      rand_rdy = 1'b0;
      repeat (2) @(posedge i_clk); #1;
      chk("rand_len", cap.size(), steady.size());
      nm = 0;
      foreach (steady[i]) if (i >= cap.size() || cap[i] !== steady[i]) nm++;
      chk("rand_seq_diffs", nm, 0);
    end

    // Reset while padding a 5-byte frame
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    cap.delete();
    expect_frame(pl, 60); send(pl, 0);
    repeat (10) @(posedge i_clk);
    #1;
    chk("pre_rst_busy", o_busy, 1);
    chk("pre_rst_pad_byte", m_data, 8'h00);
    @(negedge i_clk); #2;
    i_rst = 1'b1;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_last", m_last, 0);
    chk("midrst_m_data", m_data, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_frame_done", o_frame_done, 0);
    @(negedge i_clk); #2;
    i_rst = 1'b0;
    chk("midrst_truncated", (cap.size() < 64), 1);
    @(posedge i_clk); #1;

    pl.delete();
    for (int i = 0; i < 14; i++) pl.push_back(8'(i + 1));
    cap.delete();
    expect_frame(pl, 60); send(pl, 0); drain();
    chk("post_rst_len", cap.size(), 64);
    chk("post_rst_fcs", {cap[63], cap[62], cap[61], cap[60]},
        {ref_cap[63], ref_cap[62], ref_cap[61], ref_cap[60]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
